// File: rtl/pipe_stage_skid_reg_pkg.sv
// Shared types for the skid-buffered pipeline stage register: state encoding and perf-counter helpers.
package pipe_stage_skid_reg_pkg;

    localparam int unsigned DEFAULT_DATA_W = 64;
    localparam int unsigned PERF_CNT_W     = 32;

    typedef enum logic [1:0] {
        PIPE_EMPTY = 2'd0,
        PIPE_FULL  = 2'd1,
        PIPE_SKID  = 2'd2
    } pipe_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] value);
        return (&value) ? value : value + PERF_CNT_W'(1);
    endfunction

endpackage

// File: rtl/pipe_stage_skid_reg_sat_cnt.sv
// Saturating event counter for the stage's optional perf outputs.
// Only built when PIPE_STAGE_PERF_CNT_EN is defined.
`ifdef PIPE_STAGE_PERF_CNT_EN
module pipe_stage_skid_reg_sat_cnt
    import pipe_stage_skid_reg_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inc,
    output logic [PERF_CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= sat_inc(cnt);
        end
    end

endmodule
`endif

// File: rtl/pipe_stage_skid_reg.sv
// Valid/ready pipeline stage register with a 2-entry skid buffer, flush and legacy bubble stall.
// Optional perf counters enabled by defining PIPE_STAGE_PERF_CNT_EN.
module pipe_stage_skid_reg
    import pipe_stage_skid_reg_pkg::*;
#(
    parameter int unsigned       DATA_W      = DEFAULT_DATA_W,
    parameter logic [DATA_W-1:0] NOP_VALUE   = {DATA_W{1'b0}},
    parameter bit                BUBBLE_ZERO = 1'b1
) (
    input  logic              cpu_clk_50M,
    input  logic              cpu_rst,
    input  logic              flush,
    input  logic              stall_bubble,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_CNT_EN
    ,
    output logic [PERF_CNT_W-1:0] perf_stall_cnt,
    output logic [PERF_CNT_W-1:0] perf_bubble_cnt
`endif
);

    pipe_state_e       state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_ready_q, in_ready_d;
    logic              occupied_c, in_fire_c, out_fire_c;

    // stall_bubble masks valid, so it also blocks out_fire.
    assign occupied_c = (state_q != PIPE_EMPTY);
    assign out_valid  = occupied_c & ~stall_bubble;
    assign in_ready   = in_ready_q;
    assign in_fire_c  = in_valid & in_ready_q;
    assign out_fire_c = out_valid & out_ready;
    assign out_data   = (BUBBLE_ZERO && !out_valid) ? NOP_VALUE : main_q;

    // Next-state and datapath selection; flush overrides normal flow.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = PIPE_EMPTY;
            main_d  = NOP_VALUE;
            skid_d  = NOP_VALUE;
        end else begin
            case (state_q)
                PIPE_EMPTY: begin
                    if (in_fire_c) begin
                        main_d  = in_data;
                        state_d = PIPE_FULL;
                    end
                end
                PIPE_FULL: begin
                    if (in_fire_c && out_fire_c) begin
                        main_d = in_data;
                    end else if (out_fire_c) begin
                        state_d = PIPE_EMPTY;
                        if (BUBBLE_ZERO) begin
                            main_d = NOP_VALUE;
                        end
                    end else if (in_fire_c) begin
                        skid_d  = in_data;
                        state_d = PIPE_SKID;
                    end
                end
                PIPE_SKID: begin
                    if (out_fire_c) begin
                        main_d  = skid_q;
                        state_d = PIPE_FULL;
                    end
                end
                default: begin
                    state_d = PIPE_EMPTY;
                    main_d  = NOP_VALUE;
                    skid_d  = NOP_VALUE;
                end
            endcase
        end
    end

    // in_ready comes straight from a flop so stalls never ripple upstream combinationally.
    assign in_ready_d = (state_d != PIPE_SKID);

    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            state_q    <= PIPE_EMPTY;
            main_q     <= NOP_VALUE;
            skid_q     <= NOP_VALUE;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

`ifdef PIPE_STAGE_PERF_CNT_EN
    // Counters survive flush; only cpu_rst clears them.
    pipe_stage_skid_reg_sat_cnt u_stall_cnt (
        .clk (cpu_clk_50M),
        .rst (cpu_rst),
        .inc (out_valid & ~out_ready),
        .cnt (perf_stall_cnt)
    );

    pipe_stage_skid_reg_sat_cnt u_bubble_cnt (
        .clk (cpu_clk_50M),
        .rst (cpu_rst),
        .inc (occupied_c & stall_bubble),
        .cnt (perf_bubble_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Scoreboard bench for pipe_stage_skid_reg: directed stimulus pushes expected payloads, a monitor pops on out_fire.
module tb_pipe_stage_skid_reg;

    logic        clk = 1'b0;
    logic        rst, flush, sb, iv, ordy;
    logic        ir, ov;
    logic [63:0] id, od;
`ifdef PIPE_STAGE_PERF_CNT_EN
    logic [31:0] psc, pbc;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_q[$];
    bit          mon_en   = 1'b0;

    always #5 clk = ~clk;

    pipe_stage_skid_reg dut (
        .cpu_clk_50M  (clk),
        .cpu_rst      (rst),
        .flush        (flush),
        .stall_bubble (sb),
        .in_valid     (iv),
        .in_ready     (ir),
        .in_data      (id),
        .out_valid    (ov),
        .out_ready    (ordy),
        .out_data     (od)
`ifdef PIPE_STAGE_PERF_CNT_EN
        ,
        .perf_stall_cnt  (psc),
        .perf_bubble_cnt (pbc)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every out_fire must match the oldest expected payload; idle output must be NOP.
    always @(negedge clk) begin
        if (mon_en) begin
            if (ov === 1'b1 && ordy === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %0h expected none at %0t", od, $time);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    check("out_data_order", od, e);
                end
            end else if (ov !== 1'b1) begin
                check("idle_nop", od, 64'h0);
            end
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; sb = 1'b0; iv = 1'b1; id = 64'hA5; ordy = 1'b1;

        // Reset held two cycles with a valid input present
        tick();
        mon_en = 1'b1;
        check("rst1_out_valid", 64'(ov), 64'h0);
        check("rst1_out_data",  od,      64'h0);
        check("rst1_in_ready",  64'(ir), 64'h1);
        tick();
        check("rst2_out_valid", 64'(ov), 64'h0);
        check("rst2_out_data",  od,      64'h0);
        check("rst2_in_ready",  64'(ir), 64'h1);
        rst = 1'b0;
        exp_q.push_back(64'hA5);
        tick();
        check("first_accept_valid", 64'(ov), 64'h1);
        check("first_accept_data",  od,      64'hA5);
        iv = 1'b0;
        tick();
        check("drain_a5_valid", 64'(ov), 64'h0);

        // Streaming 1..4 back-to-back
        iv = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            id = 64'(i);
            exp_q.push_back(64'(i));
            tick();
            check("stream_valid",    64'(ov), 64'h1);
            check("stream_data",     od,      64'(i));
            check("stream_in_ready", 64'(ir), 64'h1);
        end
        iv = 1'b0;
        tick();
        check("stream_end_valid", 64'(ov), 64'h0);
        check("stream_end_data",  od,      64'h0);

        // Backpressure into SKID, then release
        ordy = 1'b0; iv = 1'b1; id = 64'h7;
        exp_q.push_back(64'h7);
        tick();
        check("bp_full_in_ready", 64'(ir), 64'h1);
        id = 64'h8;
        exp_q.push_back(64'h8);
        tick();
        check("bp_skid_in_ready", 64'(ir), 64'h0);
        check("bp_skid_valid",    64'(ov), 64'h1);
        check("bp_skid_data",     od,      64'h7);
        iv = 1'b0; ordy = 1'b1;
        tick();
        check("bp_rel_in_ready", 64'(ir), 64'h1);
        check("bp_rel_data",     od,      64'h8);
        tick();
        check("bp_done_valid", 64'(ov), 64'h0);

        // Flush while in SKID: 7, 8 and 9 must vanish
        ordy = 1'b0; iv = 1'b1; id = 64'h7;
        tick();
        id = 64'h8;
        tick();
        check("fl_skid_in_ready", 64'(ir), 64'h0);
        flush = 1'b1; id = 64'h9;
        tick();
        check("fl_out_valid", 64'(ov), 64'h0);
        check("fl_out_data",  od,      64'h0);
        check("fl_in_ready",  64'(ir), 64'h1);
        flush = 1'b0; iv = 1'b0; ordy = 1'b1;
        repeat (3) tick();
        check("fl_after_valid", 64'(ov), 64'h0);

        // Flush in FULL with a simultaneous in_fire: the incoming payload is dropped too
        ordy = 1'b0; iv = 1'b1; id = 64'h33;
        tick();
        flush = 1'b1; id = 64'h44;
        tick();
        check("fl_full_valid",    64'(ov), 64'h0);
        check("fl_full_in_ready", 64'(ir), 64'h1);
        flush = 1'b0; iv = 1'b0; ordy = 1'b1;
        repeat (2) tick();
        check("fl_full_after_valid", 64'(ov), 64'h0);

        // Bubble insertion for 3 cycles over a held payload
        iv = 1'b1; id = 64'h5;
        exp_q.push_back(64'h5);
        tick();
        iv = 1'b0; sb = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("bub_valid",    64'(ov), 64'h0);
            check("bub_data",     od,      64'h0);
            check("bub_in_ready", 64'(ir), 64'h1);
            tick();
        end
        sb = 1'b0;
        #1;
        check("bub_release_valid", 64'(ov), 64'h1);
        check("bub_release_data",  od,      64'h5);
        tick();
        check("bub_done_valid", 64'(ov), 64'h0);

`ifdef PIPE_STAGE_PERF_CNT_EN
        // Perf counters: stall count, survival across flush, bubble count, reset clear
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("perf_rst_stall",  64'(psc), 64'h0);
        check("perf_rst_bubble", 64'(pbc), 64'h0);
        iv = 1'b1; id = 64'h55; ordy = 1'b0;
        exp_q.push_back(64'h55);
        tick();
        iv = 1'b0;
        repeat (10) tick();
        check("perf_stall_10", 64'(psc), 64'd10);
        ordy = 1'b1;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("perf_stall_after_flush", 64'(psc), 64'd10);
        iv = 1'b1; id = 64'h66;
        exp_q.push_back(64'h66);
        tick();
        iv = 1'b0; sb = 1'b1;
        repeat (3) tick();
        check("perf_bubble_3", 64'(pbc), 64'd3);
        sb = 1'b0;
        tick();
        check("perf_stall_unchanged", 64'(psc), 64'd10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("perf_clr_stall",  64'(psc), 64'h0);
        check("perf_clr_bubble", 64'(pbc), 64'h0);
`endif

        tick();
        check("queue_drained", 64'(exp_q.size()), 64'h0);
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
